priority_arbiter_4_rr: RTL and testbench
========================================

PRIORITY_ARBITER_4_RR -- requirements
Module: priority_arbiter_4_rr

Interface
REQ-001 The block SHALL have a parameter MAX_HOLD, default 16, giving the maximum number of consecutive cycles one grant is held (legal range 2..256).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req  input  4  request per requester, index 3..0.
REQ-005 release  input  1  current owner done; valid only while gnt_valid=1.
REQ-006 rr_en  input  1  1 = round-robin priority, 0 = fixed priority; sampled only in IDLE.
REQ-007 gnt  output  4  one-hot grant, registered.
REQ-008 gnt_id  output  2  encoded index of the granted requester, registered.
REQ-009 gnt_valid  output  1  high while any grant is held.
REQ-010 timeout  output  1  one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-012 In IDLE, with req != 0, the block SHALL select a winner and enter GRANT; gnt, gnt_id and gnt_valid SHALL assert on the next edge, giving a latency of 1 cycle from req to gnt.
REQ-013 In IDLE, with req == 0, the block SHALL stay in IDLE with gnt=0, gnt_id=0 and gnt_valid=0.
REQ-014 Fixed mode SHALL use priority order 3 > 2 > 1 > 0, with the highest set index winning.
REQ-015 Round-robin mode SHALL search (last_id-1), (last_id-2), (last_id-3), last_id mod 4, in that order, and the first set request SHALL win.
REQ-016 last_id SHALL update to the winner's index on every grant, in both modes.
REQ-017 gnt SHALL always be one-hot or zero; gnt_id SHALL equal the index of the set bit in gnt.
REQ-018 hold_cnt SHALL be 0 in the first GRANT cycle, increment by 1 each subsequent GRANT cycle, and have width clog2(MAX_HOLD).
REQ-019 GRANT SHALL exit to IDLE on the edge after any of the following:
  - release=1;
  - req[gnt_id]=0;
  - hold_cnt == MAX_HOLD-1.
  gnt SHALL be 0 in the following cycle.
REQ-020 timeout SHALL pulse for 1 cycle, coincident with the first IDLE cycle, only when the exit cause was the hold limit alone.
REQ-021 When release or req-drop coincides with hold_cnt == MAX_HOLD-1, timeout SHALL stay 0.
REQ-022 There SHALL be at least one IDLE cycle between consecutive grants, including a re-grant to the same requester.
REQ-023 Changes on non-owner req bits during GRANT SHALL be ignored.
REQ-024 A change of rr_en during GRANT SHALL have no effect until the next IDLE cycle.
REQ-025 release asserted in IDLE SHALL be ignored.

Reset
REQ-026 While rst=1 the block SHALL hold: state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, hold_cnt=0, last_id=0.
REQ-027 Assertion of rst mid-grant SHALL clear all outputs immediately, without waiting for clk.
REQ-028 After rst deasserts, the first arbitration SHALL occur on the first clk edge with req != 0.

Structure
REQ-029 A shared package arbiter_pkg SHALL hold the IDLE/GRANT state encoding, the requester count (4) and the ID width (2).
REQ-030 The combinational winner selection (rotate by last_id, then a 4-to-2 priority encode with any-valid flag) SHALL be one sub-module, priority_pick_4.
REQ-031 All outputs SHALL be driven directly from flops.

Verification
REQ-032 Fixed mode, rr_en=0, req=4'b1010 held -> gnt=4'b1000, gnt_id=3 one cycle later; release=1 for 1 cycle -> gnt=0 for 1 cycle, then gnt=4'b1000 again.
REQ-033 Round-robin mode, rr_en=1, req=4'b1111 held, release pulsed on every grant -> gnt_id sequence 3,2,1,0,3 with a 1-cycle gap between each.
REQ-034 MAX_HOLD=4, req=4'b0001 held, no release -> gnt_valid high for exactly 4 cycles, then timeout=1 for 1 cycle with gnt=0, then re-grant to 0.
REQ-035 Owner req drops on the same cycle that hold_cnt reaches MAX_HOLD-1 -> grant ends and timeout stays 0.
REQ-036 rst asserted mid-grant (gnt=4'b0100) -> gnt=0 and gnt_valid=0 without a clk edge; after release of rst, round-robin restarts from last_id=0 (req=4'b1111 -> gnt_id=3).
REQ-037 req=4'b0000 for 10 cycles, then 4'b0100 -> gnt stays 0 for those cycles, then gnt=4'b0100 exactly one cycle after req rises.

Source files
------------

// File: rtl/priority_arbiter_4_rr_pkg.sv
// Shared definitions for the 4-requester arbiter: FSM encoding, requester count and ID width.
package arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/priority_arbiter_4_rr_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface priority_arbiter_4_rr_if;
    import arbiter_pkg::*;

    logic [N_REQ-1:0] i_req;
    logic             i_release;
    logic             i_rr_en;
    logic [N_REQ-1:0] o_gnt;
    logic [ID_W-1:0]  o_gnt_id;
    logic             o_gnt_valid;
    logic             o_timeout;

    modport master (
        output i_req, i_release, i_rr_en,
        input  o_gnt, o_gnt_id, o_gnt_valid, o_timeout
    );

    modport slave (
        input  i_req, i_release, i_rr_en,
        output o_gnt, o_gnt_id, o_gnt_valid, o_timeout
    );

endinterface

// File: rtl/priority_arbiter_4_rr_pick.sv
// Combinational winner pick: searches base-1, base-2, base-3, base (mod 4); first set request wins.
module priority_pick_4
    import arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_base,
    output logic [ID_W-1:0]  o_id,
    output logic             o_valid
);

    logic [ID_W-1:0] w_idx;

    // Walk from lowest to highest priority so the last hit is the winner.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        o_id    = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = i_base - ID_W'(k);
            if (i_req[w_idx]) begin
                o_id    = w_idx;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_arbiter_4_rr.sv
// Two-state arbiter with fixed or round-robin priority, a hold limit and a timeout pulse.
module priority_arbiter_4_rr
    import arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    priority_arbiter_4_rr_if.slave    bus
);

    localparam int CW = $clog2(MAX_HOLD);

    state_t           r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [ID_W-1:0]  r_gnt_id;
    logic             r_gnt_valid;
    logic             r_timeout;
    logic [CW-1:0]    r_hold_cnt;
    logic [ID_W-1:0]  r_last_id;

    logic [ID_W-1:0]  w_base;
    logic [ID_W-1:0]  w_win_id;
    logic             w_win_valid;
    logic             w_release;
    logic             w_drop;
    logic             w_limit;

    // Fixed priority is the round-robin search anchored at 0 (order 3,2,1,0).
    assign w_base = bus.i_rr_en ? r_last_id : '0;

    priority_pick_4 u_pick (
        .i_req   (bus.i_req),
        .i_base  (w_base),
        .o_id    (w_win_id),
        .o_valid (w_win_valid)
    );

    assign w_release = bus.i_release;
    assign w_drop    = ~bus.i_req[r_gnt_id];
    assign w_limit   = (r_hold_cnt == CW'(MAX_HOLD - 1));

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_hold_cnt  <= '0;
            r_last_id   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_timeout <= 1'b0;
                    if (w_win_valid) begin
                        r_state     <= ST_GRANT;
                        r_gnt       <= N_REQ'(1) << w_win_id;
                        r_gnt_id    <= w_win_id;
                        r_gnt_valid <= 1'b1;
                        r_hold_cnt  <= '0;
                        r_last_id   <= w_win_id;
                    end
                end
                ST_GRANT: begin
                    if (w_release || w_drop || w_limit) begin
                        r_state     <= ST_IDLE;
                        r_gnt       <= '0;
                        r_gnt_id    <= '0;
                        r_gnt_valid <= 1'b0;
                        r_hold_cnt  <= '0;
                        r_timeout   <= w_limit && !w_release && !w_drop;
                    end else begin
                        r_hold_cnt  <= r_hold_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_gnt       = r_gnt;
    assign bus.o_gnt_id    = r_gnt_id;
    assign bus.o_gnt_valid = r_gnt_valid;
    assign bus.o_timeout   = r_timeout;

endmodule

// File: tb/tb_priority_arbiter_4_rr.sv
// Directed bench for priority_arbiter_4_rr with MAX_HOLD=4 and hand-computed expectations.
module tb_priority_arbiter_4_rr;
    import arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    priority_arbiter_4_rr_if bus ();

    priority_arbiter_4_rr #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                              input logic v, input logic to);
        check({tag, ".gnt"},       32'(bus.o_gnt),       32'(g));
        check({tag, ".gnt_id"},    32'(bus.o_gnt_id),    32'(id));
        check({tag, ".gnt_valid"}, 32'(bus.o_gnt_valid), 32'(v));
        check({tag, ".timeout"},   32'(bus.o_timeout),   32'(to));
    endtask

    logic [1:0] rr_seq [4] = '{2'd2, 2'd1, 2'd0, 2'd3};
    logic [3:0] rr_gnt [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};

    initial begin
        rst           = 1'b1;
        bus.i_req     = 4'b0000;
        bus.i_release = 1'b0;
        bus.i_rr_en   = 1'b0;
        #12;
        expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // No requests for 10 cycles, then a single request wins one cycle later.
        for (int i = 0; i < 10; i++) begin
            step();
            expect_out("idle_noreq", 4'b0000, 2'd0, 1'b0, 1'b0);
        end
        bus.i_req = 4'b0100;
        step();
        expect_out("first_req", 4'b0100, 2'd2, 1'b1, 1'b0);
        bus.i_req = 4'b0000;
        step();
        expect_out("drop_exit", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Fixed priority, release pulse, then re-grant after one idle cycle.
        bus.i_req = 4'b1010;
        step();
        expect_out("fixed_win", 4'b1000, 2'd3, 1'b1, 1'b0);
        bus.i_release = 1'b1;
        step();
        expect_out("fixed_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
        bus.i_release = 1'b0;
        step();
        expect_out("fixed_regrant", 4'b1000, 2'd3, 1'b1, 1'b0);
        bus.i_req = 4'b0000;
        step();

        // Non-owner changes and rr_en change during GRANT are ignored.
        bus.i_req = 4'b0010;
        step();
        expect_out("own1", 4'b0010, 2'd1, 1'b1, 1'b0);
        bus.i_req   = 4'b1011;
        bus.i_rr_en = 1'b1;
        step();
        expect_out("nonowner_ign", 4'b0010, 2'd1, 1'b1, 1'b0);
        bus.i_release = 1'b1;
        step();
        expect_out("rel_exit", 4'b0000, 2'd0, 1'b0, 1'b0);
        bus.i_release = 1'b0;
        step();
        expect_out("rr_after_1", 4'b0001, 2'd0, 1'b1, 1'b0);
        bus.i_req = 4'b0000;
        step();
        expect_out("rr_drop", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Release in IDLE has no effect; it only ends a grant once held.
        bus.i_release = 1'b1;
        step();
        expect_out("rel_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        bus.i_req = 4'b0100;
        step();
        expect_out("rel_idle_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        step();
        expect_out("rel_in_grant", 4'b0000, 2'd0, 1'b0, 1'b0);
        bus.i_release = 1'b0;
        bus.i_req     = 4'b0000;
        bus.i_rr_en   = 1'b0;
        step();

        // Hold limit: 4 grant cycles, then a timeout pulse with gnt=0, then re-grant.
        bus.i_req = 4'b0001;
        step();
        for (int i = 0; i < 4; i++) begin
            expect_out("hold", 4'b0001, 2'd0, 1'b1, 1'b0);
            if (i < 3) step();
        end
        step();
        expect_out("timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
        step();
        expect_out("to_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Owner drop on the limit cycle: no timeout.
        step(); step(); step();
        bus.i_req = 4'b0000;
        step();
        expect_out("drop_at_limit", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Release on the limit cycle: no timeout.
        bus.i_req = 4'b0001;
        step();
        step(); step(); step();
        bus.i_release = 1'b1;
        step();
        expect_out("rel_at_limit", 4'b0000, 2'd0, 1'b0, 1'b0);
        bus.i_release = 1'b0;
        bus.i_req     = 4'b0000;
        step();

        // Asynchronous reset mid-grant, then round-robin restarts from last_id=0.
        bus.i_req = 4'b0100;
        step();
        expect_out("pre_rst", 4'b0100, 2'd2, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        expect_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst         = 1'b0;
        bus.i_req   = 4'b1111;
        bus.i_rr_en = 1'b1;
        step();
        expect_out("rr_0", 4'b1000, 2'd3, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bus.i_release = 1'b1;
            step();
            expect_out("rr_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
            bus.i_release = 1'b0;
            step();
            expect_out("rr_seq", rr_gnt[i], rr_seq[i], 1'b1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
